ro_issue_ctrl: RTL

Issue controller in front of the dual-slot read-operand stage. It decides each cycle whether the ID pair (slot a, slot b) enters RO together, slot a alone, or not at all, and it holds ID while the pair is split. After a special op issues, it serialises the pipeline by blocking all issue until EX/MEM/WB have drained. Its outputs gate the RO stage's per-slot ready inputs and feed the ID stall.

---
 rtl/ro_issue_ctrl_pkg.sv | 26 ++
 rtl/ro_pair_check.sv | 51 +++++
 rtl/ro_issue_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ro_issue_ctrl_pkg.sv
// Shared types for the read-operand issue controller slice.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Contents: issue_state_t (controller FSM state), mem_type_t (decoded
// memory class of an ID slot), is_mem_op() helper.
package ro_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IS_NORMAL = 2'd0,
    IS_SPLIT  = 2'd1,
    IS_DRAIN  = 2'd2
  } issue_state_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_AMO   = 2'd3
  } mem_type_t;

  function automatic logic is_mem_op(input mem_type_t t);
    return (t != MEM_NONE);
  endfunction

endpackage

// File: rtl/ro_pair_check.sv
// Decides whether the ID pair must be split across two issue cycles.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by ro_issue_ctrl.
//
// Ports: a_ready_i/b_ready_i slot valid, a_dest_i slot a destination,
// b_src1_i/b_src2_i slot b sources, a_mem_i/b_mem_i memory class,
// a_is_branch_i/b_is_branch_i, b_is_spec_op_i; conflict_o result.
// Build option: DUAL_ISSUE_EN enables pairing; without it every ready pair
// is reported as conflicting so the pair always splits.
import ro_issue_ctrl_pkg::*;

module ro_pair_check (
  input  logic       a_ready_i,
  input  logic       b_ready_i,
  input  logic [4:0] a_dest_i,
  input  logic [4:0] b_src1_i,
  input  logic [4:0] b_src2_i,
  input  mem_type_t  a_mem_i,
  input  mem_type_t  b_mem_i,
  input  logic       a_is_branch_i,
  input  logic       b_is_branch_i,
  input  logic       b_is_spec_op_i,
  output logic       conflict_o
);

  logic both_ready;
  logic raw_hit;
  logic rule_hit;

  assign both_ready = a_ready_i & b_ready_i;

  // Conservative RAW: src2 is compared even when slot b uses an immediate.
  assign raw_hit = (a_dest_i != 5'd0) &&
                   ((a_dest_i == b_src1_i) || (a_dest_i == b_src2_i));

  assign rule_hit = raw_hit
                  | (is_mem_op(a_mem_i) & is_mem_op(b_mem_i))
                  | (a_is_branch_i & b_is_branch_i)
                  | b_is_spec_op_i;

`ifdef DUAL_ISSUE_EN
  assign conflict_o = both_ready & rule_hit;
`else
  // Single-issue build: the rule result is kept only so the datapath
  // stays identical between builds.
  logic unused_rule_hit;
  assign unused_rule_hit = rule_hit;
  assign conflict_o      = both_ready;
`endif

endmodule

// File: rtl/ro_issue_ctrl.sv
// Issue controller for the dual-slot RO stage: co-issue, split, or drain.
// Latency: issue/stall are combinational from state and same-cycle inputs.
// Backpressure: ro_stall blocks all issue and raises id_stall; flush wins.
//
// Ports: clk, reset (async active-low), flush, ro_stall, pipe_empty,
// ID slot a/b fields (ready, dest, b sources, mem type, branch, spec op,
// a branch mistaken); outputs issue_a, issue_b, id_stall, issue_state.
// Build option: DUAL_ISSUE_EN (see ro_pair_check) enables pair co-issue.
import ro_issue_ctrl_pkg::*;

module ro_issue_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         ro_stall,
  input  logic         pipe_empty,
  input  logic         id_a_ready,
  input  logic         id_b_ready,
  input  logic [4:0]   id_a_dest,
  input  logic [4:0]   id_b_dest,
  input  logic [4:0]   id_b_rf_src1,
  input  logic [4:0]   id_b_rf_src2,
  input  mem_type_t    id_a_mem_type,
  input  mem_type_t    id_b_mem_type,
  input  logic         id_a_is_branch,
  input  logic         id_b_is_branch,
  input  logic         id_a_is_spec_op,
  input  logic         id_b_is_spec_op,
  input  logic         id_a_branch_mistaken,
  output logic         issue_a,
  output logic         issue_b,
  output logic         id_stall,
  output issue_state_t issue_state
);

  localparam int              CNT_W   = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_CYCLES);

  issue_state_t     state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             b_pending_q, b_pending_d;

  logic conflict;
  logic issue_a_c, issue_b_c, id_stall_c;

  // Slot b destination does not take part in any pairing rule (no WAW check).
  logic [4:0] unused_b_dest;
  assign unused_b_dest = id_b_dest;

  ro_pair_check u_pair_check (
    .a_ready_i      (id_a_ready),
    .b_ready_i      (id_b_ready),
    .a_dest_i       (id_a_dest),
    .b_src1_i       (id_b_rf_src1),
    .b_src2_i       (id_b_rf_src2),
    .a_mem_i        (id_a_mem_type),
    .b_mem_i        (id_b_mem_type),
    .a_is_branch_i  (id_a_is_branch),
    .b_is_branch_i  (id_b_is_branch),
    .b_is_spec_op_i (id_b_is_spec_op),
    .conflict_o     (conflict)
  );

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    b_pending_d = b_pending_q;
    issue_a_c   = 1'b0;
    issue_b_c   = 1'b0;
    id_stall_c  = 1'b0;

    // The drain counter runs every DRAIN cycle, ro_stall or not.
    if ((state_q == IS_DRAIN) && (drain_cnt_q < CNT_MAX)) begin
      drain_cnt_d = drain_cnt_q + CNT_W'(1);
    end

    if (flush) begin
      state_d     = IS_NORMAL;
      drain_cnt_d = '0;
      b_pending_d = 1'b0;
    end else if (ro_stall) begin
      id_stall_c = 1'b1;
    end else begin
      unique case (state_q)
        IS_NORMAL: begin
          if (!id_a_ready && !id_b_ready) begin
            // nothing to issue
          end else if (!id_a_ready) begin
            issue_b_c = 1'b1;
          end else if (id_a_is_spec_op) begin
            // Serialise: slot b (if still on the right path) waits out
            // the drain in ID and issues through SPLIT afterwards.
            issue_a_c   = 1'b1;
            b_pending_d = id_b_ready & ~id_a_branch_mistaken;
            id_stall_c  = b_pending_d;
            state_d     = IS_DRAIN;
            drain_cnt_d = '0;
          end else if (id_a_branch_mistaken) begin
            // Slot b is wrong-path: dropped, ID may advance.
            issue_a_c = 1'b1;
          end else if (!id_b_ready) begin
            issue_a_c = 1'b1;
          end else if (conflict) begin
            issue_a_c  = 1'b1;
            id_stall_c = 1'b1;
            state_d    = IS_SPLIT;
          end else begin
            issue_a_c = 1'b1;
            issue_b_c = 1'b1;
          end
        end

        IS_SPLIT: begin
          issue_b_c = 1'b1;
          if (id_b_is_spec_op) begin
            state_d     = IS_DRAIN;
            drain_cnt_d = '0;
            b_pending_d = 1'b0;
          end else begin
            state_d = IS_NORMAL;
          end
        end

        IS_DRAIN: begin
          id_stall_c = 1'b1;
          if ((drain_cnt_q >= CNT_MAX) && pipe_empty) begin
            state_d     = b_pending_q ? IS_SPLIT : IS_NORMAL;
            b_pending_d = 1'b0;
          end
        end

        default: begin
          state_d = IS_NORMAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IS_NORMAL;
      drain_cnt_q <= '0;
      b_pending_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      b_pending_q <= b_pending_d;
    end
  end

  // Outputs are combinational, so reset must mask them directly to be
  // quiet for the whole time reset is held, not just after the next edge.
  assign issue_a     = reset & issue_a_c;
  assign issue_b     = reset & issue_b_c;
  assign id_stall    = reset & id_stall_c;
  assign issue_state = state_q;

endmodule
